// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: turns single-cycle core memory requests into a valid/ready
// bus transaction, stalls the core until the response, and flags misalign/timeout.
module lsu_bus_bridge #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Store,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_valid_q, req_valid_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        misalign_q, misalign_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic       req;
  logic [3:0] be_calc;
  logic       mis_calc;
  logic       timeout_hit;

  always_comb begin
    req         = MemRead | MemWrite;
    be_calc     = 4'b1111;
    mis_calc    = 1'b0;
    case (Store)
      2'b00: be_calc = 4'b0001 << Mem_WrAddr[1:0];
      2'b01: begin
        be_calc  = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
        mis_calc = Mem_WrAddr[0];
      end
      default: begin
        be_calc  = 4'b1111;
        mis_calc = (Mem_WrAddr[1:0] != 2'b00);
      end
    endcase
    // The cycle that brings the REQ+WAIT count up to TIMEOUT aborts the access.
    timeout_hit = (cnt_q == (TIMEOUT - 8'd1));
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    req_valid_d = req_valid_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    misalign_d  = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (mis_calc) begin
            misalign_d = 1'b1;
            rdata_d    = 32'd0;
            state_d    = DONE;
          end else begin
            addr_d      = {Mem_WrAddr[31:2], 2'b00};
            wdata_d     = Mem_WrData;
            be_d        = be_calc;
            we_d        = MemWrite;
            req_valid_d = 1'b1;
            cnt_d       = 8'd0;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_req_ready && bus_rsp_valid) begin
          req_valid_d = 1'b0;
          if (!we_q) rdata_d = bus_rdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          req_valid_d = 1'b0;
          err_d       = 1'b1;
          rdata_d     = 32'd0;
          state_d     = DONE;
        end else if (bus_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A response landing on the timeout cycle still completes normally.
        if (bus_rsp_valid) begin
          if (!we_q) rdata_d = bus_rdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rdata_q     <= 32'd0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      misalign_q  <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      req_valid_q <= req_valid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      misalign_q  <= misalign_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign Stall         = ((state_q == IDLE) && req) || (state_q == REQ) || (state_q == WAIT);
  assign ReadData      = rdata_q;
  assign bus_req_valid = req_valid_q;
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_be        = be_q;
  assign misalign      = misalign_q;
  assign bus_err       = err_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge with a short timeout so the abort path is reachable.
module tb_lsu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [1:0]  Store;
  logic [31:0] Mem_WrAddr, Mem_WrData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  logic        misalign, bus_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd_model = 32'd0;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .Store(Store),
    .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData),
    .ReadData(ReadData), .Stall(Stall),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata),
    .misalign(misalign), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Aligned access with ready in the first REQ cycle and response one cycle later.
  task automatic normal_access(input string tag, input logic wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rsp, input logic [31:0] exp_addr,
                               input logic [3:0] exp_be);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = wr; Store = size; Mem_WrAddr = addr; Mem_WrData = wdata;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, 32'(Stall), 32'd1);
    chk({tag, "_idle_valid"}, 32'(bus_req_valid), 32'd0);
    @(negedge clk); #1;
    chk({tag, "_req_valid"}, 32'(bus_req_valid), 32'd1);
    chk({tag, "_req_addr"}, bus_addr, exp_addr);
    chk({tag, "_req_be"}, 32'(bus_be), 32'(exp_be));
    chk({tag, "_req_we"}, 32'(bus_we), 32'(wr));
    chk({tag, "_req_wdata"}, bus_wdata, wdata);
    chk({tag, "_req_stall"}, 32'(Stall), 32'd1);
    @(negedge clk);
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = rsp;
    #1;
    chk({tag, "_wait_valid"}, 32'(bus_req_valid), 32'd0);
    chk({tag, "_wait_stall"}, 32'(Stall), 32'd1);
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    #1;
    if (!wr) rd_model = rsp;
    chk({tag, "_done_stall"}, 32'(Stall), 32'd0);
    chk({tag, "_done_rdata"}, ReadData, rd_model);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    chk({tag, "_after_stall"}, 32'(Stall), 32'd0);
    chk({tag, "_after_valid"}, 32'(bus_req_valid), 32'd0);
    $display("txn %s: addr=0x%08h be=%b we=%b rdata=0x%08h", tag, exp_addr, exp_be, wr, ReadData);
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Store = 2'b00;
    Mem_WrAddr = 32'd0; Mem_WrData = 32'd0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'd0;
    #1;
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_valid", 32'(bus_req_valid), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset: released");

    normal_access("word_load", 1'b0, 2'b10, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111);
    normal_access("byte_store", 1'b1, 2'b00, 32'h0000_0203, 32'hAAAA_AAAA, 32'h1234_5678, 32'h0000_0200, 4'b1000);

    // Timeout: ready never comes, request withdrawn after 4 REQ cycles.
    @(negedge clk);
    MemRead = 1'b1; Store = 2'b10; Mem_WrAddr = 32'h0000_0300; bus_req_ready = 1'b0;
    #1;
    chk("to_idle_stall", 32'(Stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("to_req_valid", 32'(bus_req_valid), 32'd1);
      chk("to_req_stall", 32'(Stall), 32'd1);
    end
    @(negedge clk); #1;
    rd_model = 32'd0;
    chk("to_done_valid", 32'(bus_req_valid), 32'd0);
    chk("to_done_err", 32'(bus_err), 32'd1);
    chk("to_done_rdata", ReadData, rd_model);
    chk("to_done_stall", 32'(Stall), 32'd0);
    @(negedge clk);
    MemRead = 1'b0;
    #1;
    chk("to_err_sticky", 32'(bus_err), 32'd1);
    $display("txn timeout: bus_err=%b rdata=0x%08h", bus_err, ReadData);

    normal_access("load_after_to", 1'b0, 2'b11, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 32'h0000_0104, 4'b1111);

    // Misaligned half load: no bus traffic, one-cycle misalign pulse.
    @(negedge clk);
    MemRead = 1'b1; Store = 2'b01; Mem_WrAddr = 32'h0000_0101;
    #1;
    chk("mis_idle_stall", 32'(Stall), 32'd1);
    chk("mis_idle_valid", 32'(bus_req_valid), 32'd0);
    @(negedge clk); #1;
    rd_model = 32'd0;
    chk("mis_done_pulse", 32'(misalign), 32'd1);
    chk("mis_done_valid", 32'(bus_req_valid), 32'd0);
    chk("mis_done_rdata", ReadData, rd_model);
    chk("mis_done_stall", 32'(Stall), 32'd0);
    @(negedge clk);
    MemRead = 1'b0;
    #1;
    chk("mis_pulse_end", 32'(misalign), 32'd0);
    $display("txn misalign: addr=0x00000101 rdata=0x%08h", ReadData);

    // Ready held low 3 cycles; response arrives with ready on the timeout cycle.
    @(negedge clk);
    MemRead = 1'b1; Store = 2'b01; Mem_WrAddr = 32'h0000_0402; Mem_WrData = 32'h7777_8888;
    bus_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Mem_WrAddr = 32'hFFFF_FFF0 + 32'(i); Mem_WrData = 32'h0BAD_0000 + 32'(i);
      #1;
      chk("hold_valid", 32'(bus_req_valid), 32'd1);
      chk("hold_addr", bus_addr, 32'h0000_0400);
      chk("hold_be", 32'(bus_be), 32'hC);
      chk("hold_wdata", bus_wdata, 32'h7777_8888);
    end
    @(negedge clk);
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rdata = 32'h5555_AAAA;
    #1;
    chk("hold_last_valid", 32'(bus_req_valid), 32'd1);
    @(negedge clk);
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    #1;
    rd_model = 32'h5555_AAAA;
    chk("hold_done_rdata", ReadData, rd_model);
    chk("hold_done_valid", 32'(bus_req_valid), 32'd0);
    chk("hold_done_stall", 32'(Stall), 32'd0);
    chk("hold_err_sticky", 32'(bus_err), 32'd1);
    @(negedge clk);
    MemRead = 1'b0;
    $display("txn hold: addr=0x00000400 be=1100 rdata=0x%08h", ReadData);

    // Async reset while waiting for the response.
    @(negedge clk);
    MemRead = 1'b1; Store = 2'b10; Mem_WrAddr = 32'h0000_0500; bus_req_ready = 1'b1;
    @(negedge clk); #1;
    chk("ar_req_valid", 32'(bus_req_valid), 32'd1);
    @(negedge clk);
    bus_req_ready = 1'b0;
    #1;
    chk("ar_wait_stall", 32'(Stall), 32'd1);
    #2;
    reset = 1'b1; MemRead = 1'b0;
    #1;
    rd_model = 32'd0;
    chk("ar_stall", 32'(Stall), 32'd0);
    chk("ar_valid", 32'(bus_req_valid), 32'd0);
    chk("ar_err", 32'(bus_err), 32'd0);
    chk("ar_rdata", ReadData, rd_model);
    chk("ar_addr", bus_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    $display("txn async_reset: Stall=%b valid=%b err=%b", Stall, bus_req_valid, bus_err);

    normal_access("load_after_rst", 1'b0, 2'b10, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 32'h0000_0600, 4'b1111);
    chk("final_err", 32'(bus_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit that sits directly downstream of the CPU datapath's memory port (Mem_WrAddr, Mem_WrData, ReadData).
- Converts each single-cycle load/store request into a valid/ready bus transaction with byte enables.
- Stalls the core until the response arrives, and returns the word-aligned read data to the datapath's load-extend stage.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before the access is aborted. Width is 8 bits; legal range is 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemRead  input  1  current instruction is a load.
- MemWrite  input  1  current instruction is a store.
- Store  input  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- Mem_WrAddr  input  32  byte address from the ALU.
- Mem_WrData  input  32  store data, already lane-replicated by store_extend.
- ReadData  output  32  raw aligned word returned to load_extend.
- Stall  output  1  freezes the PC and register writes while high.
- bus_req_valid  output  1  request valid.
- bus_req_ready  input  1  slave accepts the request.
- bus_we  output  1  1 = write.
- bus_addr  output  32  {Mem_WrAddr[31:2], 2'b00}.
- bus_wdata  output  32  latched Mem_WrData.
- bus_be  output  4  byte enables.
- bus_rsp_valid  input  1  response (read data or write ack) valid.
- bus_rdata  input  32  response data.
- misalign  output  1  one-cycle pulse on a misaligned access.
- bus_err  output  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async): state=IDLE. ReadData=0, Stall=0, bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, misalign=0, bus_err=0, timeout counter=0. A transaction in flight is dropped; the slave must tolerate the withdrawn request.
- Request detect: req = MemRead | MemWrite. If both are high, the access is a write.
- Stall (combinational) = (IDLE & req) | REQ | WAIT. Stall is low in DONE so the instruction retires on that edge.
- Byte enables:
  - byte: be = 1 << addr[1:0].
  - half: be = addr[1] ? 4'b1100 : 4'b0011.
  - word: be = 4'b1111.
  - Reads use the same be.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, req, aligned: latch bus_addr, bus_wdata, bus_be, bus_we; set bus_req_valid=1; go to REQ.
  - IDLE, req, misaligned: no bus traffic; misalign=1 for the next cycle; ReadData=0; go to DONE.
  - REQ: hold all bus outputs stable while bus_req_valid=1. When bus_req_ready=1, clear bus_req_valid and go to WAIT. If bus_rsp_valid is also high in that same cycle, capture the response and go to DONE directly.
  - WAIT: on bus_rsp_valid, ReadData<=bus_rdata (reads only; writes leave ReadData unchanged) and go to DONE.
  - DONE: one cycle, then IDLE unconditionally. The instruction's request is ignored in DONE, so it does not retrigger.
- Latency: with zero-wait ready and response one cycle after acceptance, a request seen in cycle 0 gives Stall=1 for cycles 0–2, DONE in cycle 3, retire at the end of cycle 3.
- Timeout: the counter clears on entry to REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT: bus_req_valid=0, bus_err<=1, ReadData<=0, go to DONE. A response arriving in the same cycle as the timeout wins.
- bus_rsp_valid outside WAIT (or outside the REQ same-cycle case) is ignored.
- ReadData holds its value until the next completed read or reset.

Test Plan:
- Word load, addr 0x100, ready on 1st REQ cycle, rsp one cycle later with 0xDEADBEEF → bus_addr=0x100, be=1111, we=0; Stall high 3 cycles; ReadData=0xDEADBEEF in DONE.
- Byte store to 0x203, data 0x000000AA replicated → bus_addr=0x200, be=1000, we=1; completes on ack; ReadData unchanged.
- Half load at 0x101 → misalign pulses 1 cycle; no bus_req_valid; ReadData=0; Stall high exactly 1 cycle.
- Word load with bus_req_ready held low, TIMEOUT=4 → bus_req_valid drops after 4 cycles; bus_err=1 and stays 1; ReadData=0; next load completes normally.
- Slave holds ready low 3 cycles → bus_addr/be/wdata stable throughout; transaction completes after ready.
- Async reset asserted in WAIT → Stall, bus_req_valid, bus_err drop to 0 immediately (no clock edge needed); FSM returns to IDLE; next request proceeds normally.
